// File: rtl/bnn_fc.sv
// Binarized fully-connected layer: ten XNOR/popcount class accumulators over FEAT_N features.
// Define BNN_FC_SAT_EN to saturate the accumulators instead of wrapping modulo 1024.
module bnn_fc #(
  parameter int unsigned FEAT_N = 169
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic signed [4:0] feat_sum,
  input  logic              feat_valid,
  input  logic [9:0]        weight_bits,
  output logic              busy,
  output logic signed [9:0] fc_result_0,
  output logic signed [9:0] fc_result_1,
  output logic signed [9:0] fc_result_2,
  output logic signed [9:0] fc_result_3,
  output logic signed [9:0] fc_result_4,
  output logic signed [9:0] fc_result_5,
  output logic signed [9:0] fc_result_6,
  output logic signed [9:0] fc_result_7,
  output logic signed [9:0] fc_result_8,
  output logic signed [9:0] fc_result_9,
  output logic              fc_result_valid
);

  localparam int unsigned NCLS  = 10;
  localparam int unsigned ACC_W = 10;
  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q [NCLS];
  logic signed [ACC_W-1:0]  acc_d [NCLS];
  logic                     valid_q, valid_d;
  logic                     feat_bit_c;

  assign feat_bit_c = (feat_sum > 5'sd0);

  // One +/-1 step of a class accumulator.
  function automatic logic signed [ACC_W-1:0] acc_step(input logic signed [ACC_W-1:0] a,
                                                       input logic up);
`ifdef BNN_FC_SAT_EN
    if (up) return (a == 10'sh1FF) ? a : a + 10'sd1;
    else    return (a == 10'sh200) ? a : a - 10'sd1;
`else
    return up ? a + 10'sd1 : a - 10'sd1;
`endif
  endfunction

  // Next-state: start always wins, restarting the accumulation from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    valid_d = 1'b0;
    if (start) begin
      state_d = ACC;
      cnt_d   = '0;
      for (int k = 0; k < NCLS; k++) acc_d[k] = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        ACC: begin
          if (feat_valid) begin
            for (int k = 0; k < NCLS; k++)
              acc_d[k] = acc_step(acc_q[k], ~(feat_bit_c ^ weight_bits[k]));
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FEAT_N - 1)) begin
              state_d = DONE;
              valid_d = 1'b1;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < NCLS; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      for (int k = 0; k < NCLS; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign busy            = (state_q == ACC);
  assign fc_result_valid = valid_q;
  assign fc_result_0     = acc_q[0];
  assign fc_result_1     = acc_q[1];
  assign fc_result_2     = acc_q[2];
  assign fc_result_3     = acc_q[3];
  assign fc_result_4     = acc_q[4];
  assign fc_result_5     = acc_q[5];
  assign fc_result_6     = acc_q[6];
  assign fc_result_7     = acc_q[7];
  assign fc_result_8     = acc_q[8];
  assign fc_result_9     = acc_q[9];

endmodule

// File: tb/tb_bnn_fc.sv
// Bench for bnn_fc: behavioural score model checked every cycle, plus literal scenario checks.
module tb_bnn_fc;
  localparam int unsigned FN = 4;
  localparam int unsigned FB = 600;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              feat_valid;
  logic signed [4:0] feat_sum;
  logic [9:0]        weight_bits;
  logic              busy4, v4, busy6, v6;
  logic signed [9:0] r4 [10];
  logic signed [9:0] r6 [10];

  always #5 clk = ~clk;

  bnn_fc #(.FEAT_N(FN)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .feat_sum(feat_sum), .feat_valid(feat_valid),
    .weight_bits(weight_bits), .busy(busy4),
    .fc_result_0(r4[0]), .fc_result_1(r4[1]), .fc_result_2(r4[2]), .fc_result_3(r4[3]),
    .fc_result_4(r4[4]), .fc_result_5(r4[5]), .fc_result_6(r4[6]), .fc_result_7(r4[7]),
    .fc_result_8(r4[8]), .fc_result_9(r4[9]), .fc_result_valid(v4));

  bnn_fc #(.FEAT_N(FB)) dut600 (
    .clk(clk), .rstn(rstn), .start(start), .feat_sum(feat_sum), .feat_valid(feat_valid),
    .weight_bits(weight_bits), .busy(busy6),
    .fc_result_0(r6[0]), .fc_result_1(r6[1]), .fc_result_2(r6[2]), .fc_result_3(r6[3]),
    .fc_result_4(r6[4]), .fc_result_5(r6[5]), .fc_result_6(r6[6]), .fc_result_7(r6[7]),
    .fc_result_8(r6[8]), .fc_result_9(r6[9]), .fc_result_valid(v6));

  int n_chk = 0;
  int n_fail = 0;
  int n_pulse = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int e0, input int erest);
    for (int k = 0; k < 10; k++)
      chk($sformatf("%s_score%0d", nm, k), int'(r4[k]), (k == 0) ? e0 : erest);
  endtask

  // Model: exact integer scores, then viewed through the 10-bit two's complement output.
  int m_phase = 0;
  int m_cnt = 0;
  int m_sc [10];
  bit m_valid = 1'b0;

  function automatic int m_add(input int a, input int d);
    int s;
    s = a + d;
`ifdef BNN_FC_SAT_EN
    if (s > 511) s = 511;
    if (s < -512) s = -512;
`endif
    return s;
  endfunction

  function automatic int m_view(input int s);
    int w;
    w = s & 1023;
    if (w >= 512) w -= 1024;
    return w;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
      for (int k = 0; k < 10; k++) m_sc[k] = 0;
    end else begin
      m_valid = 1'b0;
      if (start) begin
        m_phase = 1;
        m_cnt   = 0;
        for (int k = 0; k < 10; k++) m_sc[k] = 0;
      end else if (m_phase == 1 && feat_valid) begin
        for (int k = 0; k < 10; k++)
          m_sc[k] = m_add(m_sc[k], ((feat_sum > 0) == weight_bits[k]) ? 1 : -1);
        m_cnt++;
        if (m_cnt == FN) begin
          m_phase = 2;
          m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy4), (m_phase == 1) ? 1 : 0);
    chk("valid", int'(v4), int'(m_valid));
    for (int k = 0; k < 10; k++)
      chk($sformatf("score%0d", k), int'(r4[k]), m_view(m_sc[k]));
    if (v4) n_pulse++;
  end

  task automatic drive(input bit s, input bit v, input int fs, input logic [9:0] w);
    start       = s;
    feat_valid  = v;
    feat_sum    = 5'(fs);
    weight_bits = w;
    @(posedge clk);
    #1;
    start      = 1'b0;
    feat_valid = 1'b0;
  endtask

  int p0;
  int fsq [4];

  initial begin
    rstn = 1'b1; start = 1'b0; feat_valid = 1'b0; feat_sum = '0; weight_bits = '0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_busy", int'(busy4), 0);
    chk("rst_valid", int'(v4), 0);
    chk_all("rst", 0, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // All features agree with all weights: every class scores +4.
    drive(1, 0, 0, 10'h000);
    for (int i = 0; i < 4; i++) drive(0, 1, 3, 10'h3FF);
    chk("t1_valid", int'(v4), 1);
    chk_all("t1", 4, 4);
    drive(0, 0, 0, 10'h000);
    chk("t1_valid_drop", int'(v4), 0);

    // Bits 0,0,1,1 against w=1 on class 0 only: everything cancels to 0.
    fsq = '{0, -1, 2, 5};
    drive(1, 0, 0, 10'h000);
    for (int i = 0; i < 4; i++) drive(0, 1, fsq[i], 10'h001);
    chk("t2_valid", int'(v4), 1);
    chk_all("t2", 0, 0);

    // Bits 0,0,0,1 against w=1 on class 0: class0 -2, others +2.
    fsq = '{0, -1, -3, 2};
    drive(1, 0, 0, 10'h000);
    for (int i = 0; i < 4; i++) drive(0, 1, fsq[i], 10'h001);
    chk_all("t3", -2, 2);

    // Samples in DONE are ignored and scores hold.
    for (int i = 0; i < 3; i++) drive(0, 1, 5, 10'h3FF);
    chk("t4_busy", int'(busy4), 0);
    chk_all("t4_hold", -2, 2);

    // Abort mid-run, restart with a simultaneous (discarded) feature, then gapped features.
    p0 = n_pulse;
    drive(1, 0, 0, 10'h000);
    drive(0, 1, -4, 10'h000);
    drive(0, 1, -4, 10'h000);
    drive(1, 1, 3, 10'h3FF);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 10'h000);
      drive(0, 1, 1, 10'h3FF);
    end
    chk_all("t5", 4, 4);
    drive(0, 0, 0, 10'h000);
    drive(0, 0, 0, 10'h000);
    chk("t5_pulses", n_pulse - p0, 1);

    // Asynchronous reset mid-run clears everything at once.
    drive(1, 0, 0, 10'h000);
    drive(0, 1, 3, 10'h3FF);
    drive(0, 1, 3, 10'h3FF);
    rstn = 1'b0;
    #1;
    chk("t6_busy", int'(busy4), 0);
    chk("t6_valid", int'(v4), 0);
    chk_all("t6", 0, 0);
    #2 rstn = 1'b1;
    drive(0, 1, 3, 10'h3FF);
    drive(0, 1, 3, 10'h3FF);
    chk_all("t6_idle", 0, 0);
    drive(1, 0, 0, 10'h000);
    drive(0, 1, 1, 10'h3FF);
    drive(0, 1, 1, 10'h3FF);
    drive(0, 1, -1, 10'h000);
    drive(0, 1, 0, 10'h3FF);
    chk_all("t6_run", 2, 2);

    // Randomized traffic against the model, with rare asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #3 rstn = 1'b0;
        #2 rstn = 1'b1;
      end
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
            int'($urandom_range(0, 31)) - 16, 10'($urandom_range(0, 1023)));
    end

    // Long run on the 600-feature instance exercises accumulator overflow.
    drive(1, 0, 0, 10'h000);
    for (int i = 0; i < int'(FB); i++) drive(0, 1, 1, 10'h3FF);
    chk("t7_valid", int'(v6), 1);
    for (int k = 0; k < 10; k++)
`ifdef BNN_FC_SAT_EN
      chk($sformatf("t7_score%0d", k), int'(r6[k]), 511);
`else
      chk($sformatf("t7_score%0d", k), int'(r6[k]), -424);
`endif
    drive(0, 0, 0, 10'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
